// File: rtl/jpeg_idct_transpose_ctrl.sv
// Ping-pong-free transpose controller for an 8x8 IDCT: fills a 64x16 RAM row-major, then drains it.
// Build option: define JPEG_IDCT_TRANSPOSE_EN for column-major (transposed) readout; otherwise row-major.
`timescale 1ns/1ps
module jpeg_idct_transpose_ctrl (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        inport_valid_i,
   input  logic [15:0] inport_data_i,
   output logic        inport_accept_o,
   output logic        outport_valid_o,
   output logic [15:0] outport_data_o,
   output logic [5:0]  outport_idx_o,
   output logic        outport_last_o,
   input  logic        outport_accept_i,
   output logic [5:0]  ram_addr0_o,
   output logic [15:0] ram_data0_o,
   output logic        ram_wr0_o,
   output logic [5:0]  ram_addr1_o,
   input  logic [15:0] ram_data1_i
);

   typedef enum logic {FILL, DRAIN} state_t;

   state_t      state_reg;
   logic [5:0]  wr_cnt_reg;
   logic [5:0]  rd_cnt_reg;
   logic [5:0]  rd_cnt_next;
   logic        rd_pend_reg;
   logic        valid_reg;
   logic        last_reg;
   logic [5:0]  addr1_reg;
   logic        in_fill;
   logic        out_hs;

   function automatic logic [5:0] rd_addr(input logic [5:0] cnt);
`ifdef JPEG_IDCT_TRANSPOSE_EN
      return {cnt[2:0], cnt[5:3]};
`else
      return cnt;
`endif
   endfunction

   assign in_fill     = (state_reg == FILL);
   assign out_hs      = valid_reg && outport_accept_i;
   assign rd_cnt_next = rd_cnt_reg + 6'd1;

   // Write side is combinational so the word lands in RAM on the same edge it is accepted.
   assign inport_accept_o = in_fill && !rst_i;
   assign ram_wr0_o       = in_fill && inport_valid_i && !rst_i;
   assign ram_addr0_o     = wr_cnt_reg;
   assign ram_data0_o     = inport_data_i;

   // The RAM re-reads every cycle, so holding the address holds the data during a stall.
   assign ram_addr1_o     = addr1_reg;
   assign outport_idx_o   = addr1_reg;
   assign outport_data_o  = ram_data1_i;
   assign outport_valid_o = valid_reg;
   assign outport_last_o  = last_reg;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg   <= FILL;
         wr_cnt_reg  <= 6'd0;
         rd_cnt_reg  <= 6'd0;
         rd_pend_reg <= 1'b0;
         valid_reg   <= 1'b0;
         last_reg    <= 1'b0;
         addr1_reg   <= 6'd0;
      end else begin
         case (state_reg)
            FILL: begin
               if (inport_valid_i) begin
                  wr_cnt_reg <= wr_cnt_reg + 6'd1;
                  if (wr_cnt_reg == 6'd63) begin
                     state_reg   <= DRAIN;
                     rd_cnt_reg  <= 6'd0;
                     addr1_reg   <= rd_addr(6'd0);
                     rd_pend_reg <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (rd_pend_reg) begin
                  // RAM has just sampled addr1_reg; its data is on ram_data1_i next cycle.
                  rd_pend_reg <= 1'b0;
                  valid_reg   <= 1'b1;
                  last_reg    <= (rd_cnt_reg == 6'd63);
               end else if (out_hs) begin
                  valid_reg <= 1'b0;
                  last_reg  <= 1'b0;
                  if (rd_cnt_reg == 6'd63) begin
                     rd_cnt_reg <= 6'd0;
                     addr1_reg  <= 6'd0;
                     state_reg  <= FILL;
                  end else begin
                     rd_cnt_reg  <= rd_cnt_next;
                     addr1_reg   <= rd_addr(rd_cnt_next);
                     rd_pend_reg <= 1'b1;
                  end
               end
            end
            default: state_reg <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_jpeg_idct_transpose_ctrl.sv
// Directed bench for jpeg_idct_transpose_ctrl with a behavioural 64x16 registered-read RAM.
`timescale 1ns/1ps
module tb_jpeg_idct_transpose_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        inport_valid_i = 1'b0;
   logic [15:0] inport_data_i = 16'h0;
   logic        inport_accept_o;
   logic        outport_valid_o;
   logic [15:0] outport_data_o;
   logic [5:0]  outport_idx_o;
   logic        outport_last_o;
   logic        outport_accept_i = 1'b1;
   logic [5:0]  ram_addr0_o;
   logic [15:0] ram_data0_o;
   logic        ram_wr0_o;
   logic [5:0]  ram_addr1_o;
   logic [15:0] ram_data1_i;

   int errors = 0;
   int checks = 0;
   int last_cnt = 0;

   logic [15:0] mem [0:63];

   jpeg_idct_transpose_ctrl dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .inport_valid_i  (inport_valid_i),
      .inport_data_i   (inport_data_i),
      .inport_accept_o (inport_accept_o),
      .outport_valid_o (outport_valid_o),
      .outport_data_o  (outport_data_o),
      .outport_idx_o   (outport_idx_o),
      .outport_last_o  (outport_last_o),
      .outport_accept_i(outport_accept_i),
      .ram_addr0_o     (ram_addr0_o),
      .ram_data0_o     (ram_data0_o),
      .ram_wr0_o       (ram_wr0_o),
      .ram_addr1_o     (ram_addr1_o),
      .ram_data1_i     (ram_data1_i)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      if (ram_wr0_o) mem[ram_addr0_o] <= ram_data0_o;
      ram_data1_i <= mem[ram_addr1_o];
   end

   function automatic int exp_addr(input int k);
`ifdef JPEG_IDCT_TRANSPOSE_EN
      return (k % 8) * 8 + (k / 8);
`else
      return k;
`endif
   endfunction

   task automatic fill_block(input logic [15:0] base, input int start, input int n);
      for (int i = start; i < n; i++) begin
         @(negedge clk_i);
         inport_valid_i = 1'b1;
         inport_data_i  = base + 16'(i);
         #1;
         checks++;
         if (inport_accept_o !== 1'b1 || ram_wr0_o !== 1'b1) begin
            errors++;
            $display("FAIL fill_accept i=%0d: accept=%b wr0=%b required 1/1", i, inport_accept_o, ram_wr0_o);
         end
         checks++;
         if (ram_addr0_o !== 6'(i) || ram_data0_o !== base + 16'(i)) begin
            errors++;
            $display("FAIL fill_write i=%0d: addr=%0d data=%h required %0d/%h", i, ram_addr0_o, ram_data0_o, i, base + 16'(i));
         end
         checks++;
         if (outport_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL fill_valid i=%0d: valid=%b required 0", i, outport_valid_o);
         end
      end
   endtask

   task automatic drain_block(input logic [15:0] base, input bit do_stall, input bit hold_in, input logic [15:0] hold_data);
      int k = 0;
      int stall_left;
      int cycles = 0;
      logic [5:0]  exp_i;
      logic [15:0] exp_d;
      stall_left = do_stall ? 10 : 0;
      @(negedge clk_i);
      inport_valid_i   = hold_in;
      inport_data_i    = hold_data;
      outport_accept_i = 1'b1;
      #1;
      checks++;
      if (outport_valid_o !== 1'b0 || inport_accept_o !== 1'b0 || ram_addr1_o !== 6'd0) begin
         errors++;
         $display("FAIL drain_entry: valid=%b accept=%b addr1=%0d required 0/0/0", outport_valid_o, inport_accept_o, ram_addr1_o);
      end
      while (k < 64) begin
         @(negedge clk_i);
         #1;
         cycles++;
         if (cycles > 400) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: word=%0d outstanding after %0d cycles, required completion", k, cycles);
            return;
         end
         exp_i = 6'(exp_addr(k));
         exp_d = base + 16'(exp_i);
         checks++;
         if (outport_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL out_valid word=%0d: valid=%b required 1", k, outport_valid_o);
            return;
         end
         checks++;
         if (outport_data_o !== exp_d || outport_idx_o !== exp_i) begin
            errors++;
            $display("FAIL out_data word=%0d: data=%h idx=%0d required %h/%0d", k, outport_data_o, outport_idx_o, exp_d, exp_i);
         end
         checks++;
         if (outport_last_o !== (k == 63)) begin
            errors++;
            $display("FAIL out_last word=%0d: last=%b required %b", k, outport_last_o, (k == 63));
         end
         if (hold_in) begin
            checks++;
            if (inport_accept_o !== 1'b0 || ram_wr0_o !== 1'b0) begin
               errors++;
               $display("FAIL drain_inhibit word=%0d: accept=%b wr0=%b required 0/0", k, inport_accept_o, ram_wr0_o);
            end
         end
         if (k == 2 && stall_left > 0) begin
            outport_accept_i = 1'b0;
            stall_left--;
         end else begin
            outport_accept_i = 1'b1;
            if (outport_last_o === 1'b1) last_cnt++;
            $display("out word=%0d idx=%0d data=%h last=%b", k, outport_idx_o, outport_data_o, outport_last_o);
            @(negedge clk_i);
            #1;
            checks++;
            if (outport_valid_o !== 1'b0 || outport_last_o !== 1'b0) begin
               errors++;
               $display("FAIL bubble word=%0d: valid=%b last=%b required 0/0", k, outport_valid_o, outport_last_o);
            end
            if (k == 63) begin
               checks++;
               if (inport_accept_o !== 1'b1) begin
                  errors++;
                  $display("FAIL refill_accept: accept=%b required 1", inport_accept_o);
               end
               if (hold_in) begin
                  checks++;
                  if (ram_wr0_o !== 1'b1 || ram_addr0_o !== 6'd0 || ram_data0_o !== hold_data) begin
                     errors++;
                     $display("FAIL refill_write: wr0=%b addr=%0d data=%h required 1/0/%h", ram_wr0_o, ram_addr0_o, ram_data0_o, hold_data);
                  end
               end
            end
            k++;
         end
      end
   endtask

   task automatic check_in_reset(input string name);
      checks++;
      if (outport_valid_o !== 1'b0 || outport_last_o !== 1'b0 || ram_wr0_o !== 1'b0 || ram_addr1_o !== 6'd0) begin
         errors++;
         $display("FAIL %s: valid=%b last=%b wr0=%b addr1=%0d required 0/0/0/0", name, outport_valid_o, outport_last_o, ram_wr0_o, ram_addr1_o);
      end
   endtask

   task automatic test_reset();
      inport_valid_i = 1'b1;
      repeat (3) @(negedge clk_i);
      #1;
      check_in_reset("reset_hold");
      inport_valid_i = 1'b0;
      rst_i = 1'b0;
      #1;
      checks++;
      if (inport_accept_o !== 1'b1 || ram_addr0_o !== 6'd0 || outport_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: accept=%b addr0=%0d valid=%b required 1/0/0", inport_accept_o, ram_addr0_o, outport_valid_o);
      end
      $display("reset released");
   endtask

   task automatic test_basic();
      fill_block(16'h0000, 0, 64);
      drain_block(16'h0000, 1'b0, 1'b0, 16'h0000);
   endtask

   task automatic test_stall();
      fill_block(16'h0000, 0, 64);
      drain_block(16'h0000, 1'b1, 1'b0, 16'h0000);
   endtask

   task automatic test_hold_input();
      fill_block(16'h0100, 0, 64);
      drain_block(16'h0100, 1'b0, 1'b1, 16'h2000);
      fill_block(16'h2000, 1, 64);
      drain_block(16'h2000, 1'b0, 1'b0, 16'h0000);
   endtask

   task automatic test_reset_mid_fill();
      fill_block(16'h0500, 0, 30);
      @(negedge clk_i);
      inport_valid_i = 1'b0;
      #3 rst_i = 1'b1;
      #1;
      check_in_reset("reset_mid_fill");
      @(negedge clk_i);
      rst_i = 1'b0;
      fill_block(16'h1000, 0, 64);
      drain_block(16'h1000, 1'b0, 1'b0, 16'h0000);
   endtask

   task automatic test_reset_mid_drain();
      fill_block(16'h3000, 0, 64);
      @(negedge clk_i);
      inport_valid_i   = 1'b0;
      outport_accept_i = 1'b1;
      repeat (6) @(negedge clk_i);
      #3 rst_i = 1'b1;
      #1;
      check_in_reset("reset_mid_drain");
      @(negedge clk_i);
      rst_i = 1'b0;
      fill_block(16'h4000, 0, 64);
      drain_block(16'h4000, 1'b0, 1'b0, 16'h0000);
   endtask

   task automatic test_back_to_back();
      int last_before;
      last_before = last_cnt;
      fill_block(16'h0A00, 0, 64);
      drain_block(16'h0A00, 1'b0, 1'b0, 16'h0000);
      fill_block(16'h0B00, 0, 64);
      drain_block(16'h0B00, 1'b0, 1'b0, 16'h0000);
      checks++;
      if (last_cnt - last_before !== 2) begin
         errors++;
         $display("FAIL back_to_back_last: pulses=%0d required 2", last_cnt - last_before);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_hold_input();
      test_reset_mid_fill();
      test_reset_mid_drain();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
